minterm_encoder16: RTL and testbench

- Inverse of the cascaded 2x4 decoder tree: takes a 16-bit minterm set (bit i = minterm i of ABCD, A = MSB) and serially re-encodes it into 4-bit minterm indices, in ascending order.
- Sits after function-table logic. It turns a Σm(...) vector back into an index stream for display/check logic, using a valid/ready handshake.
- Load is gated by a negative enable, consistent with the decoder family.

---
 rtl/minterm_encoder16.sv | 76 +++++++
 tb/tb_minterm_encoder16.sv | 120 ++++++++++++
 2 files changed

// File: rtl/minterm_encoder16.sv
// minterm_encoder16: serially re-encodes a 16-bit minterm set into ascending 4-bit indices over valid/ready
module minterm_encoder16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        load,
  input  logic [15:0] vec,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic        none,
  output logic [4:0]  count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] shadow_q, shadow_d, rem;
  logic [3:0]  code_q, code_d;
  logic [4:0]  count_q, count_d;
  logic        valid_q, valid_d, none_q, none_d;
  function automatic logic [3:0] lowest(input logic [15:0] v);
    lowest = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) lowest = 4'(i);
  endfunction
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    valid_d  = valid_q;
    count_d  = count_q;
    none_d   = 1'b0;
    rem      = shadow_q & ~(16'd1 << code_q);
    case (state_q)
      IDLE: if (load && !EN) begin
        count_d  = '0;
        shadow_d = vec;
        code_d   = |vec ? lowest(vec) : code_q;
        valid_d  = |vec;
        none_d   = ~|vec;
        state_d  = |vec ? SCAN : DONE;
      end
      SCAN: if (ready) begin
        shadow_d = rem;
        count_d  = count_q + 5'd1;
        code_d   = |rem ? lowest(rem) : code_q;
        valid_d  = |rem;
        state_d  = |rem ? SCAN : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      none_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      none_q   <= none_d;
    end
  end
  assign code  = code_q;
  assign valid = valid_q;
  assign busy  = state_q != IDLE;
  assign done  = state_q == DONE;
  assign none  = none_q;
  assign count = count_q;
endmodule

// File: tb/tb_minterm_encoder16.sv
// tb_minterm_encoder16: table-driven scan scenarios plus hand-written enable and reset sequences
module tb_minterm_encoder16;
  logic        clk = 1'b0, rst = 1'b1, EN = 1'b1, load = 1'b0, ready = 1'b0;
  logic [15:0] vec = '0;
  logic [3:0]  code;
  logic        valid, busy, done, none;
  logic [4:0]  count;
  int checks = 0, failures = 0;
  minterm_encoder16 dut (
    .clk(clk), .rst(rst), .EN(EN), .load(load), .vec(vec), .ready(ready),
    .code(code), .valid(valid), .busy(busy), .done(done), .none(none), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] v;
    logic [15:0] pat;
    logic [63:0] codes;
    int          n;
    logic        exp_none;
    logic        midload;
  } rec_t;
  rec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input rec_t r);
    int k = 0, cyc = 0;
    logic xfer;
    EN = 1'b0; load = 1'b1; vec = r.v; ready = 1'b0;
    step();
    load = 1'b0; vec = '0;
    while (k < r.n && cyc < 100) begin
      chk("valid", valid, 1);
      chk("busy", busy, 1);
      chk("code", code, r.codes[4*k +: 4]);
      chk("count_run", count, k);
      load  = r.midload;
      vec   = r.midload ? 16'h0001 : 16'h0;
      ready = r.pat[cyc % 16];
      xfer  = ready;
      step();
      if (xfer) k++;
      cyc++;
    end
    load = 1'b0; vec = '0; ready = 1'b0;
    chk("xfers", k, r.n);
    chk("done", done, 1);
    chk("none", none, r.exp_none);
    chk("valid_done", valid, 0);
    chk("busy_done", busy, 1);
    chk("count_done", count, r.n);
    step();
    chk("done_clr", done, 0);
    chk("none_clr", none, 0);
    chk("busy_idle", busy, 0);
    chk("count_hold", count, r.n);
  endtask
  initial begin
    tbl[0] = '{16'h0DD0, 16'hFFFF, 64'h0000_0000_00BA_8764, 6,  1'b0, 1'b0};
    tbl[1] = '{16'h0DD0, 16'h9999, 64'h0000_0000_00BA_8764, 6,  1'b0, 1'b0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 64'hFEDC_BA98_7654_3210, 16, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'hFFFF, 64'h0,                   0,  1'b1, 1'b0};
    tbl[4] = '{16'h0DD0, 16'hFFFF, 64'h0000_0000_00BA_8764, 6,  1'b0, 1'b1};
    tbl[5] = '{16'h8421, 16'h5555, 64'h0000_0000_0000_FA50, 4,  1'b0, 1'b0};
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_code", code, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) run(tbl[i]);
    EN = 1'b1; load = 1'b1; vec = 16'h8001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_busy", busy, 0);
      chk("en_valid", valid, 0);
      chk("en_done", done, 0);
    end
    load = 1'b0; vec = '0; EN = 1'b0;
    load = 1'b1; vec = 16'h0DD0;
    step();
    load = 1'b0; vec = '0; ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_code", code, 8);
    chk("pre_rst_count", count, 3);
    ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_code", code, 0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("arst_nodone", done, 0);
    chk("arst_idle", busy, 0);
    load = 1'b1; vec = 16'h8000;
    step();
    load = 1'b0; vec = '0;
    chk("fresh_valid", valid, 1);
    chk("fresh_code", code, 15);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("fresh_done", done, 1);
    chk("fresh_count", count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
